// File: rtl/lcd_spi_phy_if.sv
// ---------------------------------------------------------------------------
// lcd_spi_phy_if
// Word-level handshake between the LCD interface controller and the SPI PHY.
//
//   spi_mosi_word  [31:0] controller -> PHY  transmit word (byte mode: [7:0])
//   spi_wide              controller -> PHY  1 = 32-bit, 0 = 8-bit transfer
//   spi_begin             controller -> PHY  start request (taken when idle)
//   spi_cs                controller -> PHY  chip-select request, active low
//   spi_busy              PHY -> controller  transfer in progress
//   spi_done              PHY -> controller  one-cycle completion pulse
//   spi_miso_word  [31:0] PHY -> controller  received word
//
// modport master: controller side, modport slave: PHY side.
// ---------------------------------------------------------------------------
interface lcd_spi_phy_if;
  logic [31:0] spi_mosi_word;
  logic        spi_wide;
  logic        spi_begin;
  logic        spi_cs;
  logic        spi_busy;
  logic        spi_done;
  logic [31:0] spi_miso_word;

  modport master (
    output spi_mosi_word,
    output spi_wide,
    output spi_begin,
    output spi_cs,
    input  spi_busy,
    input  spi_done,
    input  spi_miso_word
  );

  modport slave (
    input  spi_mosi_word,
    input  spi_wide,
    input  spi_begin,
    input  spi_cs,
    output spi_busy,
    output spi_done,
    output spi_miso_word
  );
endinterface

// File: rtl/lcd_spi_phy.sv
// ---------------------------------------------------------------------------
// lcd_spi_phy
// SPI mode-0 master PHY for the ILI9341 LCD bus. Shifts one 8-bit or 32-bit
// word MSB first on mosi while capturing miso, with a programmable SCLK
// half-period of CLK_DIV clk cycles (one bit = 2*CLK_DIV cycles).
//
// Parameters:
//   CLK_DIV   clk cycles per SCLK half-period, 1..255
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   ctrl      controller handshake (lcd_spi_phy_if.slave)
//   sclk      SPI clock pin, idles low
//   mosi      SPI data-out pin, holds the last transmitted bit when idle
//   miso      SPI data-in pin, sampled on the rising sclk edge
//   cs_n      SPI chip-select pin, registered copy of ctrl.spi_cs whose
//             deassertion is deferred until the transfer has finished
// ---------------------------------------------------------------------------
module lcd_spi_phy #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  lcd_spi_phy_if.slave ctrl,
  output logic         sclk,
  output logic         mosi,
  input  logic         miso,
  output logic         cs_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [31:0] tx_shift;
  logic [31:0] rx_shift;
  logic [4:0]  bit_cnt;
  logic [7:0]  div_cnt;
  logic        wide;
  logic        busy;
  logic        done;
  logic [31:0] miso_word;
  logic        div_end;

  // Last clk cycle of the current sclk half-period.
  assign div_end = (div_cnt == DIV_LAST);

  // The transmit register is left-aligned for both widths, so the pin is
  // always its MSB. It only shifts on the high->low sclk edge, which keeps
  // mosi changes inside the sclk-low phase; it is left unshifted after the
  // final bit so the pin holds that bit while idle.
  assign mosi = tx_shift[31];

  assign ctrl.spi_busy      = busy;
  assign ctrl.spi_done      = done;
  assign ctrl.spi_miso_word = miso_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sclk      <= 1'b0;
      tx_shift  <= 32'h0;
      rx_shift  <= 32'h0;
      bit_cnt   <= 5'd0;
      div_cnt   <= 8'd0;
      wide      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      miso_word <= 32'h0;
      cs_n      <= 1'b1;
    end else begin
      done <= 1'b0;

      // Chip select: assertion passes straight through, deassertion waits
      // for the bus to go idle so a word is never cut short. busy is low
      // from the cycle spi_done is visible, so cs_n rises one cycle later.
      if (!ctrl.spi_cs) begin
        cs_n <= 1'b0;
      end else if (!busy) begin
        cs_n <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ctrl.spi_begin) begin
            tx_shift <= ctrl.spi_wide ? ctrl.spi_mosi_word
                                      : {ctrl.spi_mosi_word[7:0], 24'h0};
            rx_shift <= 32'h0;
            wide     <= ctrl.spi_wide;
            bit_cnt  <= ctrl.spi_wide ? 5'd31 : 5'd7;
            div_cnt  <= 8'd0;
            busy     <= 1'b1;
            state    <= LOW;
          end
        end

        LOW: begin
          if (div_end) begin
            // Rising sclk: the slave has held miso stable through the low
            // phase, so it is captured here without a synchronizer.
            div_cnt  <= 8'd0;
            sclk     <= 1'b1;
            rx_shift <= {rx_shift[30:0], miso};
            state    <= HIGH;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        HIGH: begin
          if (div_end) begin
            div_cnt <= 8'd0;
            sclk    <= 1'b0;
            if (bit_cnt != 5'd0) begin
              tx_shift <= {tx_shift[30:0], 1'b0};
              bit_cnt  <= bit_cnt - 5'd1;
              state    <= LOW;
            end else begin
              // Byte transfers land in the low byte with the rest zeroed.
              miso_word <= wide ? rx_shift : {24'h0, rx_shift[7:0]};
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_phy.sv
`timescale 1ns/1ps
module tb_lcd_spi_phy;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_spi_phy_if ifa ();
  lcd_spi_phy_if ifb ();

  logic sclk_a, mosi_a, miso_a, cs_n_a;
  logic sclk_b, mosi_b, miso_b, cs_n_b;

  lcd_spi_phy #(.CLK_DIV(2)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (ifa),
    .sclk (sclk_a),
    .mosi (mosi_a),
    .miso (miso_a),
    .cs_n (cs_n_a)
  );

  lcd_spi_phy #(.CLK_DIV(1)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (ifb),
    .sclk (sclk_b),
    .mosi (mosi_b),
    .miso (miso_b),
    .cs_n (cs_n_b)
  );

  // miso model for dut_a: loopback, or a pattern shifted one bit per
  // falling sclk edge so each rising edge sees the next pattern bit.
  logic        miso_loop = 1'b1;
  logic        pat_load = 1'b0;
  logic [31:0] pat_val = 32'h0;
  logic [31:0] miso_pat;
  logic        sclk_d;

  always @(posedge clk) begin
    sclk_d <= sclk_a;
    if (pat_load) miso_pat <= pat_val;
    else if (sclk_d && !sclk_a) miso_pat <= {miso_pat[30:0], 1'b0};
  end

  assign miso_a = miso_loop ? mosi_a : miso_pat[31];
  assign miso_b = mosi_b;

  // Views indexed by DUT number for the monitor.
  logic [1:0]  done_v, busy_v, sclk_v, mosi_v, csn_v;
  logic [31:0] rxw_v [2];
  assign done_v   = {ifb.spi_done, ifa.spi_done};
  assign busy_v   = {ifb.spi_busy, ifa.spi_busy};
  assign sclk_v   = {sclk_b, sclk_a};
  assign mosi_v   = {mosi_b, mosi_a};
  assign csn_v    = {cs_n_b, cs_n_a};
  assign rxw_v[0] = ifa.spi_miso_word;
  assign rxw_v[1] = ifb.spi_miso_word;

  typedef struct {
    logic [31:0] tx;
    logic [31:0] rx;
    int          nbits;
    int          busy;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input int d, input logic [31:0] tx, input logic [31:0] rx,
                            input int nbits, input int busy);
    exp_t e;
    e.tx = tx; e.rx = rx; e.nbits = nbits; e.busy = busy;
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  // Monitor state per DUT.
  int          busy_cnt [2];
  int          edge_cnt [2];
  int          cs_hi    [2];
  logic [31:0] tx_acc   [2];
  logic        sclk_p   [2];
  logic        busy_p   [2];

  task automatic check_done(input int d);
    exp_t e;
    int   sz;
    sz = (d == 0) ? q_a.size() : q_b.size();
    if (sz == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL dut%0d unexpected_done: got spi_done=1 want no pending transfer", d);
    end else begin
      if (d == 0) e = q_a.pop_front();
      else        e = q_b.pop_front();
      $display("txn dut%0d tx=%h rx=%h busy=%0d sclk_edges=%0d", d, tx_acc[d], rxw_v[d],
               busy_cnt[d], edge_cnt[d]);
      chk($sformatf("dut%0d rx_word", d), rxw_v[d], e.rx);
      chk($sformatf("dut%0d mosi_bits", d), tx_acc[d], e.tx);
      chk($sformatf("dut%0d sclk_edges", d), 32'(edge_cnt[d]), 32'(e.nbits));
      chk($sformatf("dut%0d busy_cycles", d), 32'(busy_cnt[d]), 32'(e.busy));
      chk($sformatf("dut%0d cs_n_high_while_busy", d), 32'(cs_hi[d]), 32'd0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      busy_cnt[d] = 0; edge_cnt[d] = 0; cs_hi[d] = 0; tx_acc[d] = 0;
      sclk_p[d] = 1'b0; busy_p[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          busy_cnt[d] = 0; edge_cnt[d] = 0; cs_hi[d] = 0; tx_acc[d] = 0;
        end else begin
          if (busy_v[d] && !busy_p[d]) begin
            busy_cnt[d] = 0; edge_cnt[d] = 0; cs_hi[d] = 0; tx_acc[d] = 0;
          end
          if (busy_v[d]) begin
            busy_cnt[d]++;
            if (csn_v[d]) cs_hi[d]++;
          end
          if (sclk_v[d] && !sclk_p[d]) begin
            edge_cnt[d]++;
            tx_acc[d] = {tx_acc[d][30:0], mosi_v[d]};
          end
          if (done_v[d]) check_done(d);
        end
        sclk_p[d] = sclk_v[d];
        busy_p[d] = busy_v[d];
      end
    end
  end

  task automatic start(input int d, input logic [31:0] w, input logic wd);
    @(negedge clk);
    if (d == 0) begin
      ifa.spi_mosi_word = w; ifa.spi_wide = wd; ifa.spi_begin = 1'b1;
    end else begin
      ifb.spi_mosi_word = w; ifb.spi_wide = wd; ifb.spi_begin = 1'b1;
    end
    @(negedge clk);
    if (d == 0) ifa.spi_begin = 1'b0;
    else        ifb.spi_begin = 1'b0;
  endtask

  task automatic wait_done(input int d, input int max);
    int n = 0;
    while (!done_v[d] && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!done_v[d]) begin
      n_cmp++;
      n_err++;
      $display("FAIL dut%0d wait_done: got no spi_done in %0d cycles want spi_done", d, max);
    end
  endtask

  task automatic load_pat(input logic [31:0] v);
    @(negedge clk);
    pat_val  = v;
    pat_load = 1'b1;
    @(negedge clk);
    pat_load = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifa.spi_mosi_word = 32'h0; ifa.spi_wide = 1'b0; ifa.spi_begin = 1'b0; ifa.spi_cs = 1'b1;
    ifb.spi_mosi_word = 32'h0; ifb.spi_wide = 1'b0; ifb.spi_begin = 1'b0; ifb.spi_cs = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset sclk", 32'(sclk_a), 32'd0);
    chk("reset mosi", 32'(mosi_a), 32'd0);
    chk("reset cs_n", 32'(cs_n_a), 32'd1);
    chk("reset busy", 32'(ifa.spi_busy), 32'd0);
    chk("reset done", 32'(ifa.spi_done), 32'd0);
    chk("reset miso_word", ifa.spi_miso_word, 32'h0);
    chk("reset b cs_n", 32'(cs_n_b), 32'd1);
    rst_n = 1'b1;

    // Chip-select assertion while idle
    ifa.spi_cs = 1'b0;
    @(negedge clk);
    chk("cs_assert", 32'(cs_n_a), 32'd0);

    // Byte TX 0x2C, loopback
    expect_txn(0, 32'h2C, 32'h2C, 8, 32);
    start(0, 32'hDEAD_BE2C, 1'b0);
    wait_done(0, 100);

    // Word TX/RX loopback; mosi then holds the last bit (1)
    expect_txn(0, 32'hA5C3_0F81, 32'hA5C3_0F81, 32, 128);
    start(0, 32'hA5C3_0F81, 1'b1);
    wait_done(0, 300);
    @(negedge clk);
    chk("mosi_idle_hold", 32'(mosi_a), 32'd1);

    // Pattern-driven miso: all ones word, then 0x93 byte zero-extended
    miso_loop = 1'b0;
    load_pat(32'hFFFF_FFFF);
    expect_txn(0, 32'h1234_5678, 32'hFFFF_FFFF, 32, 128);
    start(0, 32'h1234_5678, 1'b1);
    wait_done(0, 300);
    load_pat({8'h93, 24'h0});
    expect_txn(0, 32'h0, 32'h0000_0093, 8, 32);
    start(0, 32'h0, 1'b0);
    repeat (20) @(negedge clk);
    chk("rx_hold_mid_transfer", ifa.spi_miso_word, 32'hFFFF_FFFF);
    wait_done(0, 100);
    miso_loop = 1'b1;

    // Begin while busy is ignored; begin right after done is accepted
    expect_txn(0, 32'hA7, 32'hA7, 8, 32);
    start(0, 32'hA7, 1'b0);
    repeat (9) @(negedge clk);
    ifa.spi_mosi_word = 32'h55; ifa.spi_begin = 1'b1;
    @(negedge clk);
    ifa.spi_begin = 1'b0;
    wait_done(0, 100);
    expect_txn(0, 32'h3C, 32'h3C, 8, 32);
    ifa.spi_mosi_word = 32'h3C; ifa.spi_wide = 1'b0; ifa.spi_begin = 1'b1;
    @(negedge clk);
    ifa.spi_begin = 1'b0;
    chk("b2b_busy", 32'(ifa.spi_busy), 32'd1);
    wait_done(0, 100);

    // CS deassertion held off until after done
    expect_txn(0, 32'hE1, 32'hE1, 8, 32);
    start(0, 32'hE1, 1'b0);
    repeat (4) @(negedge clk);
    ifa.spi_cs = 1'b1;
    repeat (5) @(negedge clk);
    chk("cs_holdoff_mid", 32'(cs_n_a), 32'd0);
    wait_done(0, 100);
    chk("cs_at_done", 32'(cs_n_a), 32'd0);
    @(negedge clk);
    chk("cs_release", 32'(cs_n_a), 32'd1);
    ifa.spi_cs = 1'b0;
    @(negedge clk);
    chk("cs_reassert", 32'(cs_n_a), 32'd0);

    // Reset in the middle of a 32-bit transfer: no done, outputs cleared
    start(0, 32'hCAFE_F00D, 1'b1);
    repeat (52) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst sclk", 32'(sclk_a), 32'd0);
    chk("midrst cs_n", 32'(cs_n_a), 32'd1);
    chk("midrst busy", 32'(ifa.spi_busy), 32'd0);
    chk("midrst miso_word", ifa.spi_miso_word, 32'h0);
    chk("midrst done", 32'(ifa.spi_done), 32'd0);
    chk("midrst mosi", 32'(mosi_a), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // CLK_DIV=1 byte transfer after reset: 16 busy cycles
    ifb.spi_cs = 1'b0;
    expect_txn(1, 32'h6B, 32'h6B, 8, 16);
    start(1, 32'h6B, 1'b0);
    wait_done(1, 60);

    repeat (5) @(negedge clk);
    chk("queue_a_drained", 32'(q_a.size()), 32'd0);
    chk("queue_b_drained", 32'(q_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
